// File: rtl/lcd_view_pkg.sv
// Shared definitions for the LCD page scheduler: page indices, page count and
// the key debounce state encoding.
package lcd_view_pkg;

  localparam int PG_CORE = 0;
  localparam int PG_ALU  = 1;
  localparam int PG_REG0 = 2;

  typedef enum logic [1:0] {
    DB_REL,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_REL_WAIT
  } db_state_e;

  // Two fixed pages plus one page per group of four registers.
  function automatic int npages(input int nregs);
    return 2 + nregs / 4;
  endfunction

endpackage

// File: rtl/lcd_view_sched_key_debounce.sv
// Step-button conditioner: two-flop synchronizer followed by a debounce FSM that
// emits exactly one registered `step` pulse per stable press.
module key_debounce
  import lcd_view_pkg::*;
#(
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic step
);

  localparam int            CW       = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  db_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          step_q;

  // Synchronizer idles high so a released key is not seen as a press out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DB_REL;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        DB_REL: begin
          if (!sync2_q) begin
            state_q <= DB_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        DB_PRESS_WAIT: begin
          if (sync2_q) begin
            state_q <= DB_REL;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_PRESSED;
            step_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DB_PRESSED: begin
          if (sync2_q) begin
            state_q <= DB_REL_WAIT;
            cnt_q   <= '0;
          end
        end
        DB_REL_WAIT: begin
          // A low glitch during release is bounce of the same press, not a new one.
          if (!sync2_q) begin
            state_q <= DB_PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_REL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= DB_REL;
      endcase
    end
  end

  assign step = step_q;

endmodule

// File: rtl/lcd_view_sched.sv
// Time-multiplexes processor debug values onto the two 64-bit LCD fields; pages
// advance on a debounced key press or an automatic dwell timer.
module lcd_view_sched
  import lcd_view_pkg::*;
#(
  parameter  int NBITS_TOP   = 32,
  parameter  int NBITS_LCD   = 64,
  parameter  int NINSTR_BITS = 32,
  parameter  int NREGS_TOP   = 32,
  parameter  int DWELL       = 50_000_000,
  parameter  int DEBOUNCE    = 1_000_000,
  localparam int NPAGES      = npages(NREGS_TOP),
  localparam int PW          = $clog2(NPAGES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_n,
  input  logic                   auto_en,
  input  logic                   freeze,
  input  logic [NBITS_TOP-1:0]   pc,
  input  logic [NBITS_TOP-1:0]   SrcA,
  input  logic [NBITS_TOP-1:0]   SrcB,
  input  logic [NBITS_TOP-1:0]   ALUResult,
  input  logic [NBITS_TOP-1:0]   Result,
  input  logic [NBITS_TOP-1:0]   WriteData,
  input  logic [NBITS_TOP-1:0]   ReadData,
  input  logic [NINSTR_BITS-1:0] instruction,
  input  logic [NBITS_TOP-1:0]   registrador [NREGS_TOP],
  output logic [NBITS_LCD-1:0]   lcd_a,
  output logic [NBITS_LCD-1:0]   lcd_b,
  output logic [PW-1:0]          page,
  output logic                   page_strobe
);

  localparam int            DW         = $clog2(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(NPAGES - 1);

  logic                 step;
  logic                 tick;
  logic                 adv;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [PW-1:0]        page_q, page_d;
  logic                 strobe_q;
  logic [NBITS_LCD-1:0] lcd_a_q, lcd_b_q;
  logic [NBITS_LCD-1:0] mux_a, mux_b;

  key_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_key (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .step  (step)
  );

  assign tick = auto_en && (dwell_q == DWELL_LAST);
  assign adv  = step | tick;

  // A manual step restarts the full dwell so the new page is not cut short.
  always_comb begin
    dwell_d = dwell_q + 1'b1;
    if (!auto_en || adv) begin
      dwell_d = '0;
    end
  end

  always_comb begin
    page_d = page_q;
    if (adv) begin
      page_d = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
    end
  end

  always_comb begin
    mux_a = '0;
    mux_b = '0;
    if (page_q == PW'(PG_CORE)) begin
      mux_a = {pc, NBITS_TOP'(instruction)};
      mux_b = {SrcA, SrcB};
    end else if (page_q == PW'(PG_ALU)) begin
      mux_a = {ALUResult, Result};
      mux_b = {WriteData, ReadData};
    end else begin
      for (int k = 0; k < NREGS_TOP / 4; k++) begin
        if (page_q == PW'(PG_REG0 + k)) begin
          mux_a = {registrador[4*k],   registrador[4*k+1]};
          mux_b = {registrador[4*k+2], registrador[4*k+3]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q  <= '0;
      page_q   <= '0;
      strobe_q <= 1'b0;
      lcd_a_q  <= '0;
      lcd_b_q  <= '0;
    end else begin
      dwell_q  <= dwell_d;
      page_q   <= page_d;
      strobe_q <= adv;
      if (!freeze) begin
        lcd_a_q <= mux_a;
        lcd_b_q <= mux_b;
      end
    end
  end

  assign lcd_a       = lcd_a_q;
  assign lcd_b       = lcd_b_q;
  assign page        = page_q;
  assign page_strobe = strobe_q;

endmodule

// File: tb/tb_lcd_view_sched.sv
// Scoreboard bench for lcd_view_sched: expected pages are queued as stimulus is
// applied and compared whenever the DUT strobes a page change.
module tb_lcd_view_sched;

  logic        clk;
  logic        rst_n;
  logic        key_n;
  logic        auto_en;
  logic        freeze;
  logic [31:0] pc, srca, srcb, alu, res, wdata, rdata, instr;
  logic [31:0] regs [32];
  logic [63:0] lcd_a, lcd_b;
  logic [3:0]  page;
  logic        page_strobe;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int exp_page = 0;
  int exp_q[$];
  int n;
  logic [63:0] old_a, old_b;

  lcd_view_sched #(
    .NBITS_TOP   (32),
    .NBITS_LCD   (64),
    .NINSTR_BITS (32),
    .NREGS_TOP   (32),
    .DWELL       (8),
    .DEBOUNCE    (4)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .key_n       (key_n),
    .auto_en     (auto_en),
    .freeze      (freeze),
    .pc          (pc),
    .SrcA        (srca),
    .SrcB        (srcb),
    .ALUResult   (alu),
    .Result      (res),
    .WriteData   (wdata),
    .ReadData    (rdata),
    .instruction (instr),
    .registrador (regs),
    .lcd_a       (lcd_a),
    .lcd_b       (lcd_b),
    .page        (page),
    .page_strobe (page_strobe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_a(input int p);
    if (p == 0) return {pc, instr};
    if (p == 1) return {alu, res};
    return {regs[4*(p-2)], regs[4*(p-2)+1]};
  endfunction

  function automatic logic [63:0] exp_b(input int p);
    if (p == 0) return {srca, srcb};
    if (p == 1) return {wdata, rdata};
    return {regs[4*(p-2)+2], regs[4*(p-2)+3]};
  endfunction

  task automatic push_next();
    exp_page = (exp_page + 1) % 10;
    exp_q.push_back(exp_page);
  endtask

  // Returns the number of negedges until a strobe is seen, 0 on timeout.
  task automatic wait_strobe(output int cnt, input int limit);
    cnt = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (page_strobe) begin
        cnt = i;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && page_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) check_eq("strobe_unexpected", 64'(page), 64'hFFFF);
      else check_eq("page_adv", 64'(page), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    rst_n   = 1'b0;
    key_n   = 1'b1;
    auto_en = 1'b0;
    freeze  = 1'b0;
    pc      = 32'h0040_0000;
    instr   = 32'h0050_0093;
    srca    = 32'h0000_0011;
    srcb    = 32'h0000_0022;
    alu     = 32'hA1A1_0001;
    res     = 32'hB2B2_0002;
    wdata   = 32'hC3C3_0003;
    rdata   = 32'hD4D4_0004;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;

    // Reset values and live page 0
    repeat (3) @(negedge clk);
    check_eq("rst_page", 64'(page), 64'd0);
    check_eq("rst_lcd_a", lcd_a, 64'd0);
    check_eq("rst_lcd_b", lcd_b, 64'd0);
    check_eq("rst_strobe", 64'(page_strobe), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("pg0_lcd_a", lcd_a, exp_a(0));
    check_eq("pg0_lcd_b", lcd_b, exp_b(0));

    // Clean press held for 20 cycles
    push_next();
    key_n = 1'b0;
    wait_strobe(n, 20);
    check_eq("key_latency", 64'(n), 64'd8);
    check_eq("pg1_lcd_a_pre", lcd_a, exp_a(0));
    @(negedge clk);
    check_eq("pg1_lcd_a", lcd_a, {32'hA1A1_0001, 32'hB2B2_0002});
    check_eq("pg1_lcd_b", lcd_b, exp_b(1));
    repeat (11) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("hold_one_strobe", 64'(strobe_cnt), 64'd1);

    // Bounce: short low pulses never step
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0;
      repeat (2) @(negedge clk);
      key_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_eq("bounce_page", 64'(page), 64'd1);
    check_eq("bounce_strobes", 64'(strobe_cnt), 64'd1);
    push_next();
    key_n = 1'b0;
    wait_strobe(n, 20);
    check_eq("bounce_press_lat", 64'(n), 64'd8);
    repeat (2) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("pg2_lcd_a", lcd_a, exp_a(2));
    check_eq("pg2_lcd_b", lcd_b, exp_b(2));

    // Reset in the middle of a press; the held key still steps afterwards
    key_n = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_page", 64'(page), 64'd0);
    check_eq("midrst_lcd_a", lcd_a, 64'd0);
    check_eq("midrst_lcd_b", lcd_b, 64'd0);
    check_eq("midrst_strobe", 64'(page_strobe), 64'd0);
    exp_page = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_next();
    wait_strobe(n, 20);
    check_eq("midrst_step_seen", 64'(n != 0), 64'd1);
    key_n = 1'b1;
    repeat (10) @(negedge clk);

    // Freeze: fields hold while the page advances underneath
    old_a = exp_a(1);
    old_b = exp_b(1);
    freeze = 1'b1;
    pc  = 32'hCAFE_0100;
    alu = 32'h5555_AAAA;
    push_next();
    key_n = 1'b0;
    wait_strobe(n, 20);
    check_eq("frz_step_seen", 64'(n != 0), 64'd1);
    repeat (2) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("frz_page", 64'(page), 64'd2);
    check_eq("frz_lcd_a", lcd_a, old_a);
    check_eq("frz_lcd_b", lcd_b, old_b);
    freeze = 1'b0;
    @(negedge clk);
    check_eq("unfrz_lcd_a", lcd_a, exp_a(2));

    // Auto rotation from page 2 through the wrap to 0
    regs[5] = 32'hDEAD_BEEF;
    auto_en = 1'b1;
    for (int i = 0; i < 8; i++) push_next();
    for (int i = 0; i < 8; i++) begin
      wait_strobe(n, 20);
      check_eq("auto_interval", 64'(n), (i == 1) ? 64'd7 : 64'd8);
      if (i == 0) begin
        @(negedge clk);
        check_eq("pg3_deadbeef", lcd_a, {32'h1000_0004, 32'hDEAD_BEEF});
      end
    end
    check_eq("auto_wrap", 64'(page), 64'd0);
    auto_en = 1'b0;

    // Collision of step and tick advances one page; dwell restarts
    @(negedge clk);
    auto_en = 1'b1;
    key_n = 1'b0;
    push_next();
    wait_strobe(n, 20);
    check_eq("collide_lat", 64'(n), 64'd8);
    key_n = 1'b1;
    push_next();
    wait_strobe(n, 20);
    check_eq("collide_restart", 64'(n), 64'd8);

    // A mid-dwell step clears the dwell counter
    repeat (3) @(negedge clk);
    key_n = 1'b0;
    push_next();
    push_next();
    push_next();
    wait_strobe(n, 20);
    check_eq("middwell_tick", 64'(n), 64'd5);
    wait_strobe(n, 20);
    check_eq("middwell_step", 64'(n), 64'd3);
    key_n = 1'b1;
    wait_strobe(n, 20);
    check_eq("step_clears_dwell", 64'(n), 64'd8);
    auto_en = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("final_page", 64'(page), 64'd5);
    check_eq("final_lcd_a", lcd_a, exp_a(5));
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_view_sched.md
# lcd_view_sched

Display scheduler that shares the board's single 64-bit LCD (two 64-bit hex fields, `a` and `b`) between the processor's debug signals. It time-multiplexes pages of PC/instruction, datapath values and the register file onto `lcd_a`/`lcd_b`. Pages advance on a debounced push-button or on an automatic dwell timer. It sits in the board top between `top` (debug outputs) and the LCD driver.

## Interface
- `NBITS_TOP`, 32: processor word width.
- `NBITS_LCD`, 64: LCD field width; must equal 2*NBITS_TOP.
- `NINSTR_BITS`, 32: instruction width; must be ≤ NBITS_TOP.
- `NREGS_TOP`, 32: register count; must be a multiple of 4.
- `DWELL`, 50_000_000: auto-advance period in clk cycles (1 s at 50 MHz); ≥ 2.
- `DEBOUNCE`, 1_000_000: key stable time in cycles (20 ms); ≥ 2.

Ports:
- `clk`  in  1  system clock (FPGA_CLK1_50).
- `reset`  in  1  asynchronous, active-low reset (KEY[0] connects directly).
- `key_n`  in  1  raw asynchronous step button, active-low.
- `auto_en`  in  1  1 = automatic page rotation enabled.
- `freeze`  in  1  1 = hold `lcd_a`/`lcd_b` contents.
- `pc`, `SrcA`, `SrcB`, `ALUResult`, `Result`, `WriteData`, `ReadData`  in  NBITS_TOP each  debug values.
- `instruction`  in  NINSTR_BITS  current instruction.
- `registrador`  in  NBITS_TOP × NREGS_TOP  register file array.
- `lcd_a`, `lcd_b`  out  NBITS_LCD  fields driven to the LCD driver.
- `page`  out  $clog2(NPAGES)  current page index.
- `page_strobe`  out  1  one-cycle pulse on every page change.

## Operation
- NPAGES = 2 + NREGS_TOP/4. With default parameters, NPAGES = 10.
- Page contents (the upper half of each field holds the first-named value):
  - Page 0: a = {pc, zero-extended instruction}, b = {SrcA, SrcB}.
  - Page 1: a = {ALUResult, Result}, b = {WriteData, ReadData}.
  - Page 2+k, for k in 0..NREGS_TOP/4-1: a = {x[4k], x[4k+1]}, b = {x[4k+2], x[4k+3]}.
- Key path: `key_n` passes through a 2-flop synchronizer, then a debounce FSM.
  - States: REL, PRESS_WAIT, PRESSED, REL_WAIT.
  - REL → PRESS_WAIT when the synced key is 0; clear the counter.
  - PRESS_WAIT → PRESSED after the key has stayed 0 for DEBOUNCE consecutive cycles. Emit a one-cycle `step`.
  - PRESS_WAIT → REL if the key returns to 1 before then.
  - PRESSED → REL_WAIT when the key is 1.
  - REL_WAIT → REL after the key has stayed 1 for DEBOUNCE cycles. Return to PRESSED if the key goes 0 again.
  - Exactly one `step` per press; holding the key never repeats.
- Dwell counter:
  - Counts only while `auto_en` = 1.
  - At DWELL-1 it produces `tick` and returns to 0.
  - `auto_en` = 0 clears it synchronously.
  - A `step` also clears it, so the full dwell restarts after a manual advance.
- Advance:
  - On `step` OR `tick`: page ← (page == NPAGES-1) ? 0 : page+1, and `page_strobe` = 1.
  - If `step` and `tick` occur in the same cycle, advance by one page only.
- Output register:
  - When `freeze` = 0, `lcd_a`/`lcd_b` load the mux of the current `page` every cycle, so live values track.
  - When `freeze` = 1, they hold their value. `page` still advances while frozen, and the fields update on the first cycle after `freeze` falls.

## Timing
- Reset (async assert, synchronous-release by the board reset logic): page = 0, `lcd_a` = `lcd_b` = 0, `page_strobe` = 0, all counters 0, debounce FSM in REL, synchronizer flops = 1.
- Key latency: falling edge of `key_n` → `step` after 2 (sync) + DEBOUNCE + 1 cycles. `page` changes on the next edge.
- Auto latency: `page` changes DWELL cycles after `auto_en` rises or after the previous advance.
- Display latency: `page` is registered at edge t; `lcd_a`/`lcd_b` show the new page at edge t+1. Data inputs appear 1 cycle after they change.
- Reset mid-press: the FSM returns to REL. A key still held after reset produces a `step` after DEBOUNCE cycles.

## Structure
- Shared package `lcd_view_pkg`:
  - page index constants PG_CORE = 0, PG_ALU = 1, PG_REG0 = 2;
  - function `npages(nregs)`;
  - debounce state enum.
- Sub-module `key_debounce`: contains the synchronizer and debounce FSM, with parameter DEBOUNCE and ports clk, reset, key_n, step.
- Top of this block: dwell counter, page register, registered output mux.

## Test plan
All scenarios use DWELL = 8, DEBOUNCE = 4, NREGS_TOP = 32.
1. Reset: assert `reset` = 0 mid-run → `page` = 0, `lcd_a` = `lcd_b` = 0 immediately, `page_strobe` = 0.
2. Clean press: hold `key_n` = 0 for 20 cycles → exactly one `page_strobe`, `page` 0 → 1. Then `lcd_a` = {ALUResult, Result} one cycle later.
3. Bounce: toggle `key_n` with 2-cycle low pulses 5 times → no `step`. Then hold low 10 cycles → one advance.
4. Auto wrap: `auto_en` = 1 from page 9 → `page` = 0 after 8 cycles. With `registrador[5]` = 32'hDEADBEEF on page 3, `lcd_a` = 64'h????????DEADBEEF (upper word = x[4]).
5. Collision: align a `step` with the cycle the dwell counter = 7 → `page` +1 only. The dwell counter restarts, and the next tick comes 8 cycles later.
6. Freeze: `freeze` = 1, change `pc` and press the key → `lcd_a` unchanged and `page` advanced. Drop `freeze` → `lcd_a` shows the new page next cycle.
